wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone classic arbiter that lets NUM_MASTERS bus masters share one Wishbone slave.
- Sits between the test masters (start/done-sequenced write/read-verify masters) and a single memory or register slave.
- Grants whole bus cycles: ownership is held while the granted master keeps cyc asserted.
- The slave-side bus is multiplexed from the granted master; ack and read data are routed back to that master only.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- DATA_WIDTH, 16, width of the read and write data buses.
- ADDR_WIDTH, 16, width of the address bus.
- IDX_WIDTH, 2, width of the grant index; must satisfy 2**IDX_WIDTH >= NUM_MASTERS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc request; bit i belongs to master i.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data, same packing as m_adr_i.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters; valid only with the matching m_ack_o bit.
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  DATA_WIDTH  slave read data.
- grant_o  out  IDX_WIDTH  index of the current owner; meaningful only while gnt_valid_o = 1.
- gnt_valid_o  out  1  a master currently owns the bus.

Behaviour:
- Reset (asynchronous, while rst = 0):
  - state = S_IDLE, gnt_valid_o = 0, grant_o = 0.
  - last-grant pointer = NUM_MASTERS-1, so master 0 wins the first arbitration.
  - All s_* outputs = 0, m_ack_o = 0, m_dat_o = 0.
- State machine, registered: S_IDLE and S_GRANTED.
- S_IDLE:
  - If any m_cyc_i bit is 1, select the first requester scanning upward from (last+1) mod NUM_MASTERS, wrapping.
  - On that edge: register grant_o = selected index, gnt_valid_o = 1, last = selected index, go to S_GRANTED.
  - If no m_cyc_i bit is 1, stay in S_IDLE.
- S_GRANTED:
  - If m_cyc_i[grant_o] = 0 at a clock edge, go to S_IDLE and set gnt_valid_o = 0; otherwise stay.
  - Other masters' requests are ignored while in S_GRANTED; there is no preemption.
- Slave outputs are combinational from the registered grant:
  - With gnt_valid_o = 1: s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g], where g = grant_o; s_we_o, s_adr_o and s_dat_o are the slices of master g.
  - With gnt_valid_o = 0: all s_* outputs = 0.
- Return path:
  - m_ack_o[g] = s_ack_i & gnt_valid_o & m_cyc_i[g]; all other m_ack_o bits = 0.
  - m_dat_o = s_dat_i.
- Latency:
  - A request seen in S_IDLE at edge N gives s_cyc_o = 1 from edge N onward (the cycle after the request is sampled).
  - Release always inserts at least one S_IDLE cycle, so s_cyc_o = 0 for at least one cycle between owners.
  - A master that drops cyc after every ack (write, then read) re-arbitrates between its write and its read; interleaving with other masters is legal.
- Boundary cases:
  - s_ack_i = 1 while in S_IDLE: ignored, no m_ack_o bit asserts.
  - Ack and cyc drop in the same cycle: the ack is forwarded, then the bus is released at that edge.
  - Simultaneous requests from all masters: strict rotation, each master is served once per NUM_MASTERS grants.
  - Sole requester: may win consecutive grants, each separated by one S_IDLE cycle.
  - Reset mid-transfer: grant is lost immediately and the slave sees s_cyc_o = 0 asynchronously.
  - Indices >= NUM_MASTERS are never granted.

Test Plan:
- Reset with m_cyc_i = 2'b11 held: all outputs 0 → after rst rises, first edge grants master 0 (grant_o = 0, gnt_valid_o = 1); s_adr_o equals master 0's address.
- Master 1 alone does write adr 0x0003 data 0x3333, slave acks → m_ack_o = 2'b10; s_we_o = 1; after cyc drops, gnt_valid_o = 0 for 1 cycle.
- Both masters hold cyc continuously, releasing after each ack → grant sequence 0,1,0,1; m_ack_o never routed to the non-owner.
- s_ack_i pulsed high while S_IDLE → m_ack_o stays 2'b00 and state stays S_IDLE.
- Two wb_master-style masters run 16 write/read-verify transfers each at disjoint base addresses 0x0000 and 0x0100 → both report done, no read mismatch.
- rst dropped while master 0 owns the bus mid-read → s_cyc_o = 0 and gnt_valid_o = 0 the same cycle; after release, master 0 is granted first again.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: whole bus cycles are granted to one of
// NUM_MASTERS masters and held for as long as the owner keeps cyc asserted.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic                              s_ack_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [IDX_WIDTH-1:0]              grant_o,
    output logic                              gnt_valid_o
);

    typedef enum logic {S_IDLE, S_GRANTED} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0] last_q, last_d;
    logic [IDX_WIDTH-1:0] nextIdx;
    logic                 found;
    logic                 ownerCyc;
    int                   cand;

    // Last pointer starts at the top index so master 0 wins the first round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        nextIdx  = '0;
        found    = 1'b0;
        cand     = 0;
        ownerCyc = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(last_q) + 1 + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!found && (i == cand) && m_cyc_i[i]) begin
                    found   = 1'b1;
                    nextIdx = IDX_WIDTH'(i);
                end
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == IDX_WIDTH'(i)) begin
                ownerCyc = m_cyc_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANTED;
                    grant_d = nextIdx;
                    last_d  = nextIdx;
                end
            end
            S_GRANTED: begin
                if (!ownerCyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt_valid_o = (state_q == S_GRANTED);
    assign grant_o     = grant_q;

    // Read data is held at zero during reset so nothing stale reaches the masters.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_valid_o && (grant_q == IDX_WIDTH'(i))) begin
                s_cyc_o    = m_cyc_i[i];
                s_stb_o    = m_stb_i[i];
                s_we_o     = m_we_i[i];
                s_adr_o    = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o    = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                m_ack_o[i] = s_ack_i & m_cyc_i[i];
            end
        end
        m_dat_o = rst ? s_dat_i : '0;
    end

endmodule
